// File: rtl/cnt_gate_scheduler.sv
// cnt_gate_scheduler: frames the counter bank through CLEAR/GATE/SETTLE/CAPTURE and freezes counts for SPI readout.
// Latency: all outputs registered; frame = CLR_CYCLES + max(gate,1) + SETTLE_CYCLES + 1 cycles with SPI idle.
// Backpressure: CAPTURE stalls while i_ssel_n is low; PRS_SAT_DETECT_EN adds all-ones saturation flags.
module cnt_gate_scheduler #(
    parameter int NUMBER_OF_COUNTERS = 16,
    parameter int COUNTERS_WIDTH     = 8,
    parameter int GATE_WIDTH         = 16,
    parameter int CLR_CYCLES         = 32,
    parameter int SETTLE_CYCLES      = 32
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_run,
    input  logic [GATE_WIDTH-1:0]                        i_gate_len,
    input  logic [NUMBER_OF_COUNTERS-1:0]                i_chan_mask,
    input  logic                                         i_ssel_n,
    input  logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] i_cnt_data,
    output logic [NUMBER_OF_COUNTERS-1:0]                o_cnt_en,
    output logic                                         o_cnt_rst,
    output logic [NUMBER_OF_COUNTERS*COUNTERS_WIDTH-1:0] o_snapshot,
    output logic                                         o_snap_valid,
    output logic [7:0]                                   o_frame_cnt,
    output logic [NUMBER_OF_COUNTERS-1:0]                o_sat,
    output logic                                         o_busy
);
    localparam int N      = NUMBER_OF_COUNTERS;
    localparam int W      = COUNTERS_WIDTH;
    localparam int CLR_W  = $clog2(CLR_CYCLES);
    localparam int SET_W  = $clog2(SETTLE_CYCLES);
    localparam int MAX_CS = (CLR_W > SET_W) ? CLR_W : SET_W;
    localparam int CW     = (GATE_WIDTH > MAX_CS) ? GATE_WIDTH : MAX_CS;

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_CYCLES - 1);
    localparam logic [CW-1:0] SET_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, GATE, SETTLE, CAPTURE} state_t;

    state_t         state;
    logic [CW-1:0]  phase_cnt;
    logic [N-1:0]   mask;
    logic [CW-1:0]  gate_load;

    // Phase counter holds remaining cycles minus one; a zero gate length behaves as one.
    always_comb begin
        gate_load = '0;
        if (i_gate_len != '0)
            gate_load = CW'(i_gate_len) - ONE;
    end

`ifdef PRS_SAT_DETECT_EN
    logic [N-1:0] sat_next;

    always_comb begin
        sat_next = '0;
        for (int i = 0; i < N; i++)
            sat_next[i] = &i_cnt_data[W*i +: W];
    end
`else
    assign o_sat = '0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            mask         <= '0;
            o_cnt_en     <= '0;
            o_cnt_rst    <= 1'b0;
            o_snapshot   <= '0;
            o_snap_valid <= 1'b0;
            o_frame_cnt  <= '0;
            o_busy       <= 1'b0;
`ifdef PRS_SAT_DETECT_EN
            o_sat        <= '0;
`endif
        end else begin
            o_snap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_run) begin
                        state     <= CLEAR;
                        mask      <= i_chan_mask;
                        phase_cnt <= CLR_LOAD;
                        o_cnt_rst <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (phase_cnt == '0) begin
                        state     <= GATE;
                        phase_cnt <= gate_load;
                        o_cnt_rst <= 1'b0;
                        o_cnt_en  <= mask;
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                GATE: begin
                    if (phase_cnt == '0) begin
                        state     <= SETTLE;
                        phase_cnt <= SET_LOAD;
                        o_cnt_en  <= '0;
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                SETTLE: begin
                    if (phase_cnt == '0) begin
                        state     <= CAPTURE;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt - ONE;
                    end
                end
                CAPTURE: begin
                    // Snapshot is frozen while an SPI transfer is in flight.
                    if (i_ssel_n) begin
                        o_snapshot   <= i_cnt_data;
                        o_frame_cnt  <= o_frame_cnt + 8'd1;
                        o_snap_valid <= 1'b1;
`ifdef PRS_SAT_DETECT_EN
                        o_sat        <= sat_next;
`endif
                        if (i_run) begin
                            state     <= CLEAR;
                            mask      <= i_chan_mask;
                            phase_cnt <= CLR_LOAD;
                            o_cnt_rst <= 1'b1;
                        end else begin
                            state     <= IDLE;
                            phase_cnt <= '0;
                            o_busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    phase_cnt <= '0;
                    o_cnt_en  <= '0;
                    o_cnt_rst <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cnt_gate_scheduler.sv
// Bench for cnt_gate_scheduler: frame-offset model checked every cycle plus directed literal checks.
module tb_cnt_gate_scheduler;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int GW  = 16;
    localparam int CLR = 4;
    localparam int SET = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, run, ssel_n;
    logic [GW-1:0]   gate_len;
    logic [N-1:0]    chan_mask;
    logic [N*W-1:0]  cnt_data;
    logic [N-1:0]    cnt_en;
    logic            cnt_rst;
    logic [N*W-1:0]  snapshot;
    logic            snap_valid;
    logic [7:0]      frame_cnt;
    logic [N-1:0]    sat;
    logic            busy;

    cnt_gate_scheduler #(
        .NUMBER_OF_COUNTERS(N), .COUNTERS_WIDTH(W), .GATE_WIDTH(GW),
        .CLR_CYCLES(CLR), .SETTLE_CYCLES(SET)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_run(run), .i_gate_len(gate_len),
        .i_chan_mask(chan_mask), .i_ssel_n(ssel_n), .i_cnt_data(cnt_data),
        .o_cnt_en(cnt_en), .o_cnt_rst(cnt_rst), .o_snapshot(snapshot),
        .o_snap_valid(snap_valid), .o_frame_cnt(frame_cnt), .o_sat(sat), .o_busy(busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] sat_of(input logic [N*W-1:0] d);
        logic [N-1:0] s;
        s = '0;
`ifdef PRS_SAT_DETECT_EN
        for (int i = 0; i < N; i++)
            s[i] = (d[W*i +: W] == {W{1'b1}});
`endif
        return s;
    endfunction

    // Model: position within the current frame as a cycle offset from the first CLEAR cycle.
    bit             model_ok = 0;
    bit             m_active = 0;
    int             m_off = 0;
    int             m_glen = 1;
    logic [N-1:0]   m_mask = '0;
    logic [N*W-1:0] m_snap = '0;
    logic           m_valid = 1'b0;
    logic [7:0]     m_fcnt = '0;
    logic [N-1:0]   m_sat = '0;

    always @(posedge clk) begin
        if (rst) begin
            model_ok = 1;
            m_active = 0; m_off = 0; m_mask = '0; m_snap = '0;
            m_valid = 1'b0; m_fcnt = '0; m_sat = '0;
        end else if (model_ok) begin
            m_valid = 1'b0;
            if (!m_active) begin
                if (run) begin
                    m_active = 1; m_off = 0; m_mask = chan_mask;
                end
            end else if (m_off >= CLR + m_glen + SET) begin
                if (ssel_n) begin
                    m_snap = cnt_data; m_sat = sat_of(cnt_data);
                    m_fcnt = m_fcnt + 8'd1; m_valid = 1'b1;
                    if (run) begin
                        m_off = 0; m_mask = chan_mask;
                    end else begin
                        m_active = 0;
                    end
                end
            end else begin
                if (m_off == CLR - 1)
                    m_glen = (gate_len == '0) ? 1 : int'(gate_len);
                m_off++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            logic [N-1:0] e_en;
            e_en = (m_active && m_off >= CLR && m_off < CLR + m_glen) ? m_mask : '0;
            check("m_cnt_en", cnt_en, e_en);
            check("m_cnt_rst", cnt_rst, m_active && m_off < CLR);
            check("m_busy", busy, m_active);
            check("m_snapshot", snapshot, m_snap);
            check("m_snap_valid", snap_valid, m_valid);
            check("m_frame_cnt", frame_cnt, m_fcnt);
            check("m_sat", sat, m_sat);
        end
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check(name, busy, 1'b0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int rst_cnt, en_cnt, en_other, vcnt, frames, last, en_in_frame, cyc;
        logic [N-1:0] sat_lit;
`ifdef PRS_SAT_DETECT_EN
        sat_lit = 4'b1010;
`else
        sat_lit = 4'b0000;
`endif
        rst = 1'b1; run = 1'b0; ssel_n = 1'b1; gate_len = '0; chan_mask = '0; cnt_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset and idle
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_zero", {cnt_en, cnt_rst, busy, snap_valid, frame_cnt, sat, snapshot}, '0);
        end

        // Single frame
        gate_len = 16'd10; chan_mask = 4'b0101; cnt_data = 32'hAA33_5511; run = 1'b1;
        rst_cnt = 0; en_cnt = 0; vcnt = 0;
        for (int i = 1; i <= 22; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
            rst_cnt += int'(cnt_rst);
            en_cnt  += int'(cnt_en == 4'b0101);
            vcnt    += int'(snap_valid);
            if (i == 1) check("sf_rst_rise", cnt_rst, 1'b1);
            if (i == 4) check("sf_en_before", cnt_en, 4'b0000);
            if (i == 5) check("sf_en_first", cnt_en, 4'b0101);
            if (i == 20) begin
                check("sf_snapshot", snapshot, 32'hAA33_5511);
                check("sf_valid", snap_valid, 1'b1);
                check("sf_frame_cnt", frame_cnt, 8'd1);
            end
            if (i == 22) check("sf_idle", busy, 1'b0);
        end
        check("sf_rst_cycles", rst_cnt, 4);
        check("sf_en_cycles", en_cnt, 10);
        check("sf_valid_pulses", vcnt, 1);

        // Continuous frames with zero gate length, run through frame counter wrap
        pulse_reset();
        chan_mask = 4'b1111; gate_len = '0; cnt_data = 32'h0102_0304; run = 1'b1;
        frames = 0; last = -1; en_in_frame = 0; cyc = 0;
        while (frames < 256 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cnt_en != '0) en_in_frame++;
            if (snap_valid) begin
                frames++;
                if (last >= 0) check("cf_period", cyc - last, 10);
                check("cf_en_per_frame", en_in_frame, 1);
                if (frames == 255) check("cf_cnt_255", frame_cnt, 8'd255);
                if (frames == 256) check("cf_cnt_wrap", frame_cnt, 8'd0);
                last = cyc; en_in_frame = 0;
            end
        end
        check("cf_frames_done", frames, 256);
        run = 1'b0;
        wait_idle("cf_drain");

        // SPI hold-off at capture
        gate_len = 16'd3; chan_mask = 4'b0011; cnt_data = 32'h1122_3344; run = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
            if (i >= 12 && i <= 18) begin
                check("hold_snapshot", snapshot, 32'h0102_0304);
                check("hold_valid", snap_valid, 1'b0);
            end
            if (i == 19) begin
                check("hold_release_snap", snapshot, 32'h1122_3344);
                check("hold_release_valid", snap_valid, 1'b1);
            end
            if (i == 11) ssel_n = 1'b0;
            if (i == 18) ssel_n = 1'b1;
        end
        wait_idle("hold_idle");

        // Mid-frame mask and gate length changes
        gate_len = 16'd5; chan_mask = 4'b1001; cnt_data = 32'h5A5A_5A5A; run = 1'b1;
        en_cnt = 0; en_other = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
            if (i == 6) begin
                chan_mask = 4'b0110; gate_len = 16'd2;
            end
            en_cnt   += int'(cnt_en == 4'b1001);
            en_other += int'(cnt_en != 4'b1001 && cnt_en != 4'b0000);
        end
        check("mid_old_len", en_cnt, 5);
        check("mid_no_new_mask", en_other, 0);
        check("mid_snapshot", snapshot, 32'h5A5A_5A5A);

        // Reset during GATE
        gate_len = 16'd10; chan_mask = 4'b1111; cnt_data = 32'hDEAD_BEEF; run = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
            if (i == 6) check("rg_in_gate", cnt_en, 4'b1111);
            if (i == 7) rst = 1'b1;
            if (i == 8) begin
                rst = 1'b0;
                check("rg_en_off", cnt_en, 4'b0000);
                check("rg_idle", busy, 1'b0);
                check("rg_snapshot", snapshot, 32'h0);
                check("rg_frame_cnt", frame_cnt, 8'd0);
            end
        end
        repeat (20) @(negedge clk);

        // Saturation flags
        gate_len = 16'd1; chan_mask = 4'b1111; cnt_data = 32'hFF00_FF01; run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (snap_valid) begin
                vcnt = 1;
                break;
            end
            @(negedge clk);
        end
        check("sat_capture_seen", vcnt, 1);
        check("sat_flags", sat, sat_lit);
        wait_idle("sat_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
